// File: rtl/lcd_text_refresh.sv
// Write-only HD44780 16x2 driver: power-up wait, init commands, then endless
// two-line refresh from a per-frame snapshot of the 32-character buffer.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_POWERUP  | idle after reset until the panel's power-up time elapses
// S_INIT     | four init commands 0x38, 0x0C, 0x01, 0x06 (idx_q selects)
// S_L1_ADDR  | DDRAM address 0x80; text snapshot taken in its SETUP cycle
// S_L1_CHARS | 16 data writes, chars 0-15 of the snapshot
// S_L2_ADDR  | DDRAM address 0xC0
// S_L2_CHARS | 16 data writes, chars 16-31, then back to S_L1_ADDR
// Each non-POWERUP state runs the byte-write sub-FSM W_SETUP/W_PULSE/W_HOLD.

module lcd_text_refresh #(
    parameter int POWERUP_CYC = 750000,
    parameter int EN_CYC      = 25,
    parameter int CMD_CYC     = 2500,
    parameter int CLEAR_CYC   = 100000
) (
    input  logic         CLOCK_50,
    input  logic         RESET_N,
    input  logic [255:0] text,
    output logic         init_done,
    output logic         frame_done,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic         LCD_EN,
    output logic [7:0]   LCD_DATA
);

    localparam int MAX_AB  = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
    localparam int MAX_CD  = (EN_CYC > CMD_CYC) ? EN_CYC : CMD_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] PU_LAST    = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_POWERUP,
        S_INIT,
        S_L1_ADDR,
        S_L1_CHARS,
        S_L2_ADDR,
        S_L2_CHARS
    } top_t;

    typedef enum logic [1:0] {
        W_SETUP,
        W_PULSE,
        W_HOLD
    } wr_t;

    top_t             top_q, top_d;
    wr_t              wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hold_last;
    logic [3:0]       idx_q, idx_d;
    logic [255:0]     snap_q;
    logic             snap_en;
    logic             init_d, fd_d;
    logic [7:0]       byte_cur;
    logic             rs_cur;
    logic [7:0]       data_d;
    logic             rs_d, en_d;
    logic [7:0]       chars [32];

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            chars[i] = snap_q[255 - 8*i -: 8];
        end
    end

    always_comb begin
        byte_cur = 8'h00;
        rs_cur   = 1'b0;
        case (top_q)
            S_INIT: begin
                case (idx_q[1:0])
                    2'd0:    byte_cur = 8'h38;
                    2'd1:    byte_cur = 8'h0C;
                    2'd2:    byte_cur = 8'h01;
                    default: byte_cur = 8'h06;
                endcase
            end
            S_L1_ADDR:  byte_cur = 8'h80;
            S_L1_CHARS: begin
                rs_cur   = 1'b1;
                byte_cur = chars[{1'b0, idx_q}];
            end
            S_L2_ADDR:  byte_cur = 8'hC0;
            S_L2_CHARS: begin
                rs_cur   = 1'b1;
                byte_cur = chars[{1'b1, idx_q}];
            end
            default: ;
        endcase
    end

    // Clear is the only slow command; key it off the state, not the byte value,
    // so a 0x01 character is never mistaken for it.
    assign hold_last = (top_q == S_INIT && idx_q == 4'd2) ? CLEAR_LAST : CMD_LAST;

    always_comb begin
        top_d   = top_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        init_d  = init_done;
        fd_d    = 1'b0;
        snap_en = 1'b0;
        if (top_q == S_POWERUP) begin
            if (cnt_q == PU_LAST) begin
                cnt_d = '0;
                top_d = S_INIT;
                wr_d  = W_SETUP;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            case (wr_q)
                W_SETUP: begin
                    wr_d    = W_PULSE;
                    cnt_d   = '0;
                    snap_en = (top_q == S_L1_ADDR);
                end
                W_PULSE: begin
                    if (cnt_q == EN_LAST) begin
                        wr_d  = W_HOLD;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    if (cnt_q == hold_last) begin
                        cnt_d = '0;
                        wr_d  = W_SETUP;
                        case (top_q)
                            S_INIT: begin
                                if (idx_q == 4'd3) begin
                                    idx_d  = 4'd0;
                                    init_d = 1'b1;
                                    top_d  = S_L1_ADDR;
                                end else begin
                                    idx_d = idx_q + 4'd1;
                                end
                            end
                            S_L1_ADDR: top_d = S_L1_CHARS;
                            S_L1_CHARS: begin
                                idx_d = idx_q + 4'd1;
                                if (idx_q == 4'd15) top_d = S_L2_ADDR;
                            end
                            S_L2_ADDR: top_d = S_L2_CHARS;
                            S_L2_CHARS: begin
                                idx_d = idx_q + 4'd1;
                                if (idx_q == 4'd15) begin
                                    top_d = S_L1_ADDR;
                                    fd_d  = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Pins are registered copies of the decoded write phase: glitch-free, one cycle behind.
    assign en_d   = (top_q != S_POWERUP) && (wr_q == W_PULSE);
    assign rs_d   = (top_q != S_POWERUP) && rs_cur;
    assign data_d = (top_q == S_POWERUP) ? 8'h00 : byte_cur;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            top_q      <= S_POWERUP;
            wr_q       <= W_SETUP;
            cnt_q      <= '0;
            idx_q      <= 4'd0;
            snap_q     <= '0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
            LCD_EN     <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_DATA   <= 8'h00;
        end else begin
            top_q      <= top_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            init_done  <= init_d;
            frame_done <= fd_d;
            LCD_EN     <= en_d;
            LCD_RS     <= rs_d;
            LCD_DATA   <= data_d;
            if (snap_en) snap_q <= text;
        end
    end

    assign LCD_RW = 1'b0;

endmodule

// File: doc/lcd_text_refresh.md
# lcd_text_refresh

Write-only HD44780 character-LCD driver for the 16x2 panel. It takes the 256-bit, 32-character screen buffer from the game-state/menu logic and handles the panel side:

- power-up delay and initialisation command sequence;
- continuous frame refresh of both lines;
- all EN/RS/DATA bus timing.

It sits directly downstream of the screen-text generator and drives the LCD_* board pins.

## Interface
Parameters:
- POWERUP_CYC, 750000 — idle cycles after reset before first command (15 ms @ 50 MHz)
- EN_CYC, 25 — cycles LCD_EN held high per write (500 ns)
- CMD_CYC, 2500 — post-pulse wait for normal command/data writes (50 us)
- CLEAR_CYC, 100000 — post-pulse wait after the clear command 0x01 (2 ms)

Ports:
- CLOCK_50  in  1  system clock, sole clock domain
- RESET_N  in  1  asynchronous, active-low reset
- text  in  256  screen buffer; char i (0..31) = text[255-8i -: 8]; chars 0-15 are line 1, chars 16-31 are line 2
- init_done  out  1  high once the init sequence completes; stays high until reset
- frame_done  out  1  one-cycle pulse after the last char of line 2 completes its wait
- LCD_RS  out  1  0 = command, 1 = data
- LCD_RW  out  1  tied 0 (write-only)
- LCD_EN  out  1  enable strobe
- LCD_DATA  out  8  command/char byte

## Operation
Top FSM states:
- POWERUP: counts POWERUP_CYC cycles, then goes to INIT.
- INIT: four commands in order — 0x38 (8-bit, 2-line), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry increment). After the last one, init_done is set and the FSM goes to L1_ADDR.
- L1_ADDR: command 0x80. The `text` snapshot is taken in the setup cycle of this write.
- L1_CHARS: 16 data writes, chars 0-15 from the snapshot.
- L2_ADDR: command 0xC0.
- L2_CHARS: 16 data writes, chars 16-31.
- After L2_CHARS: pulse frame_done, return to L1_ADDR. The loop runs forever.

Write sub-FSM, one pass per byte:
- SETUP: 1 cycle. RS and DATA driven, EN=0.
- PULSE: EN_CYC cycles with EN=1.
- HOLD: EN=0. Lasts CLEAR_CYC cycles for 0x01, CMD_CYC cycles otherwise.
- RS and DATA are stable from SETUP through the end of HOLD.

Text and character handling:
- Changes to `text` mid-frame are ignored until the next L1_ADDR snapshot, so no frame is ever torn.
- Char bytes are sent unmodified; no filtering of non-printables.

Counters and widths:
- Delay counter is sized for the largest parameter, minimum 20 bits at the defaults.
- Char index is 4 bits and wraps 15→0 between lines.

## Timing
Reset values (asynchronously, on any RESET_N low):
- LCD_EN=0, LCD_RS=0, LCD_DATA=8'h00, LCD_RW=0
- init_done=0, frame_done=0, state=POWERUP, all counters 0

Reset mid-operation:
- Reset during PULSE drops EN immediately.
- On release, the full POWERUP and INIT sequence repeats. No partial resume.

Cycle counts:
- Each write takes 1+EN_CYC+wait cycles.
- First LCD_EN rise occurs on the (POWERUP_CYC+2)th rising edge after RESET_N deassertion.
- init_done rises the cycle after the HOLD of 0x06 ends.
- One frame = 34 writes × (1+EN_CYC+CMD_CYC) cycles, which is 85884 cycles at the defaults.
- frame_done pulses exactly once per frame, in the same cycle the FSM re-enters L1_ADDR SETUP.
- LCD_EN is never high in two consecutive writes without at least CMD_CYC low cycles between them.

## Test plan
The bench uses POWERUP_CYC=10, EN_CYC=2, CMD_CYC=5, CLEAR_CYC=20.

- **Reset then idle:** LCD_EN=0 for cycles 1-11 after release. The first EN pulse is 2 cycles long with RS=0, DATA=0x38. The next three commands are 0x0C, 0x01, 0x06. The gap after 0x01 is 20 cycles and all other gaps are 5. init_done=1 after 0x06.
- **Frame content:** text="Laser Lift      BattleBoard     ".
  - Bytes captured on EN falling edges: 0x80, then 0x4C 0x61 0x73 ... 16 chars with RS=1, then 0xC0, then "BattleBoard     ".
  - frame_done pulses once per 34 writes, every 34×8=272 cycles.
- **Mid-frame text change:** change text to "Player 1 move   Select moves    " during L1_CHARS. The rest of the current frame still shows the old string, and the next frame shows the new one in full.
- **Asynchronous reset during PULSE:** assert RESET_N low mid-EN. LCD_EN drops in the same timestep and init_done=0. After release, the 11-cycle quiet period and the 0x38 restart both occur.
- **Long run:** 5 consecutive frames. Check:
  - RS=0 exactly for 0x80/0xC0.
  - LCD_RW is always 0.
  - DATA/RS never change while EN=1.
  - No EN pulse is shorter or longer than 2 cycles.
